exec_wb_unit: RTL and testbench

Sequenced execute/write-back stage that sits between the command source and the 32 x 32 register bank. It accepts one register-to-register command at a time, drives the bank's two read-select ports and samples the operands. It computes the result with a single-cycle ALU, or with an iterative 32-step multiplier for MUL, then performs exactly one write-back through the bank's write port. Commands never overlap, so read-after-write hazards cannot occur.

---
 rtl/exec_pkg.sv | 27 ++
 rtl/exec_mul_iter.sv | 44 ++++
 rtl/exec_wb_unit.sv | 116 +++++++++++
 tb/tb_exec_wb_unit.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/exec_pkg.sv
// rtl/exec_pkg.sv - shared types and constants for the execute/write-back stage
package exec_pkg;

  localparam int WIDTH     = 32;
  localparam int AW        = 5;
  localparam int MUL_STEPS = 32;
  localparam int CNT_W     = $clog2(MUL_STEPS);

  typedef enum logic [2:0] {
    OP_ADD = 3'd0,
    OP_SUB = 3'd1,
    OP_AND = 3'd2,
    OP_OR  = 3'd3,
    OP_XOR = 3'd4,
    OP_SLT = 3'd5,
    OP_MUL = 3'd6,
    OP_SHL = 3'd7
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    EXEC = 2'd2,
    WB   = 2'd3
  } state_e;

endpackage

// File: rtl/exec_mul_iter.sv
// rtl/exec_mul_iter.sv - iterative shift-add multiplier, one partial product per clock
module exec_mul_iter
  import exec_pkg::*;
#(
  parameter int WIDTH = exec_pkg::WIDTH
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] result,
  output logic             last
);

  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] mplier;
  logic [WIDTH-1:0] acc;
  logic [CNT_W-1:0] count;

  // result already includes the current step, so the caller can latch it on the last edge
  assign result = acc + (mplier[0] ? mcand : '0);
  assign last   = (count == CNT_W'(MUL_STEPS - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      count  <= '0;
    end else if (start) begin
      mcand  <= a;
      mplier <= b;
      acc    <= '0;
      count  <= '0;
    end else begin
      acc    <= result;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      count  <= count + 1'b1;
    end
  end

endmodule

// File: rtl/exec_wb_unit.sv
// rtl/exec_wb_unit.sv - sequenced read/execute/write-back stage in front of the register bank
module exec_wb_unit
  import exec_pkg::*;
#(
  parameter int WIDTH = exec_pkg::WIDTH,
  parameter int AW    = exec_pkg::AW
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_op,
  input  logic [AW-1:0]    in_sr1,
  input  logic [AW-1:0]    in_sr2,
  input  logic [AW-1:0]    in_dr,
  output logic [AW-1:0]    rd_sr1,
  output logic [AW-1:0]    rd_sr2,
  input  logic [WIDTH-1:0] rdData1,
  input  logic [WIDTH-1:0] rdData2,
  output logic [AW-1:0]    wr_dr,
  output logic [WIDTH-1:0] wrData,
  output logic             write,
  output logic             busy,
  output logic             done
);

  state_e           state;
  op_e              op;
  logic [AW-1:0]    dr;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [WIDTH-1:0] alu_result;
  logic [WIDTH-1:0] mul_result;
  logic             mul_last;

  exec_mul_iter #(.WIDTH(WIDTH)) u_mul (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (state == READ),
    .a       (rdData1),
    .b       (rdData2),
    .result  (mul_result),
    .last    (mul_last)
  );

  always_comb begin
    alu_result = '0;
    case (op)
      OP_ADD:  alu_result = op_a + op_b;
      OP_SUB:  alu_result = op_a - op_b;
      OP_AND:  alu_result = op_a & op_b;
      OP_OR:   alu_result = op_a | op_b;
      OP_XOR:  alu_result = op_a ^ op_b;
      OP_SLT:  alu_result = {{(WIDTH-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
      OP_SHL:  alu_result = op_a << op_b[4:0];
      default: alu_result = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      op       <= OP_ADD;
      dr       <= '0;
      op_a     <= '0;
      op_b     <= '0;
      rd_sr1   <= '0;
      rd_sr2   <= '0;
      wr_dr    <= '0;
      wrData   <= '0;
      write    <= 1'b0;
      done     <= 1'b0;
      busy     <= 1'b0;
      in_ready <= 1'b0;
    end else begin
      write <= 1'b0;
      done  <= 1'b0;
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            op       <= op_e'(in_op);
            rd_sr1   <= in_sr1;
            rd_sr2   <= in_sr2;
            dr       <= in_dr;
            in_ready <= 1'b0;
            busy     <= 1'b1;
            state    <= READ;
          end else begin
            in_ready <= 1'b1;
          end
        end
        READ: begin
          op_a  <= rdData1;
          op_b  <= rdData2;
          state <= EXEC;
        end
        EXEC: begin
          if (op != OP_MUL || mul_last) begin
            wrData <= (op == OP_MUL) ? mul_result : alu_result;
            wr_dr  <= dr;
            write  <= 1'b1;
            done   <= 1'b1;
            state  <= WB;
          end
        end
        WB: begin
          busy     <= 1'b0;
          in_ready <= 1'b1;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_exec_wb_unit.sv
// tb/tb_exec_wb_unit.sv - self-checking bench with register bank and behavioural reference model
module tb_exec_wb_unit;

  localparam logic [2:0] ADD = 3'd0, SUB = 3'd1, AND_OP = 3'd2, OR_OP = 3'd3;
  localparam logic [2:0] XOR_OP = 3'd4, SLT = 3'd5, MUL = 3'd6, SHL = 3'd7;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [2:0]  in_op = '0;
  logic [4:0]  in_sr1 = '0, in_sr2 = '0, in_dr = '0;
  logic [4:0]  rd_sr1, rd_sr2, wr_dr;
  logic [31:0] rdData1, rdData2, wrData;
  logic        write, busy, done;

  logic [31:0] bank  [32];
  logic [31:0] model [32];
  logic        preload_en = 1'b0;
  logic [4:0]  preload_addr = '0;
  logic [31:0] preload_data = '0;

  typedef struct {
    logic [4:0]  dr;
    logic [31:0] data;
    int          cyc;
  } exp_t;
  exp_t exp_q[$];

  int checks = 0, failures = 0;
  int cyc = 0, edges_since_reset = 0;
  int acc_count = 0, wr_count = 0;
  int last_acc_cyc = 0, prev_acc_cyc = 0, last_wb_cyc = 0;

  always #5 clk = ~clk;

  exec_wb_unit dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_op    (in_op),
    .in_sr1   (in_sr1),
    .in_sr2   (in_sr2),
    .in_dr    (in_dr),
    .rd_sr1   (rd_sr1),
    .rd_sr2   (rd_sr2),
    .rdData1  (rdData1),
    .rdData2  (rdData2),
    .wr_dr    (wr_dr),
    .wrData   (wrData),
    .write    (write),
    .busy     (busy),
    .done     (done)
  );

  assign rdData1 = bank[rd_sr1];
  assign rdData2 = bank[rd_sr2];

  always @(posedge clk) begin
    if (preload_en) bank[preload_addr] <= preload_data;
    else if (write) bank[wr_dr] <= wrData;
  end

  always @(posedge clk) begin
    cyc <= cyc + 1;
    edges_since_reset <= reset_n ? edges_since_reset + 1 : 0;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic logic [31:0] ref_result(input logic [2:0] op, input logic [31:0] a,
                                             input logic [31:0] b);
    logic [31:0] r;
    case (op)
      ADD:     r = a + b;
      SUB:     r = a - b;
      AND_OP:  r = a & b;
      OR_OP:   r = a | b;
      XOR_OP:  r = a ^ b;
      SLT:     r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      MUL:     r = a * b;
      default: r = a << b[4:0];
    endcase
    return r;
  endfunction

  // Compare process: bank-side outputs against the architectural model, every cycle.
  always @(negedge clk) begin
    exp_t e;
    if (!reset_n) begin
      chk("write_in_reset", write, 0);
      acc_count = acc_count - exp_q.size();
      exp_q.delete();
    end else begin
      if (preload_en) model[preload_addr] = preload_data;
      chk("busy", busy, exp_q.size() != 0);
      chk("in_ready", in_ready, exp_q.size() == 0 && edges_since_reset > 0);
      chk("done_vs_write", done, write);
      if (write) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_write", 1, 0);
        end else begin
          e = exp_q.pop_front();
          chk("wr_dr", wr_dr, e.dr);
          chk("wrData", wrData, e.data);
          chk("wb_cycle", cyc, e.cyc);
          model[e.dr] = e.data;
          last_wb_cyc = cyc;
          wr_count++;
        end
      end
      if (in_valid && in_ready) begin
        e.dr   = in_dr;
        e.data = ref_result(in_op, model[in_sr1], model[in_sr2]);
        e.cyc  = cyc + ((in_op == MUL) ? 34 : 3);
        exp_q.push_back(e);
        prev_acc_cyc = last_acc_cyc;
        last_acc_cyc = cyc + 1;
        acc_count++;
      end
    end
  end

  task automatic preload(input logic [4:0] a, input logic [31:0] d);
    preload_en = 1'b1; preload_addr = a; preload_data = d;
    @(posedge clk); #1;
    preload_en = 1'b0;
  endtask

  task automatic issue(input logic [2:0] op, input logic [4:0] s1, input logic [4:0] s2,
                       input logic [4:0] d);
    int base;
    base = acc_count;
    in_op = op; in_sr1 = s1; in_sr2 = s2; in_dr = d; in_valid = 1'b1;
    for (int i = 0; i < 100 && acc_count == base; i++) begin
      @(posedge clk); #1;
    end
    if (acc_count == base) chk("accept_timeout", 0, 1);
  endtask

  task automatic wait_done();
    in_valid = 1'b0;
    for (int i = 0; i < 100 && wr_count != acc_count; i++) begin
      @(posedge clk); #1;
    end
    chk("completion", wr_count, acc_count);
    @(posedge clk); #1;
  endtask

  task automatic run(input logic [2:0] op, input logic [4:0] s1, input logic [4:0] s2,
                     input logic [4:0] d);
    issue(op, s1, s2, d);
    wait_done();
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_write", write, 0);
    chk("rst_rd_sr1", rd_sr1, 0);
    chk("rst_rd_sr2", rd_sr2, 0);
    chk("rst_wrData", wrData, 0);
    reset_n = 1'b1;
    #1 chk("ready_before_edge", in_ready, 0);
    @(posedge clk); #1;
    chk("ready_after_edge", in_ready, 1);

    preload(5'd1, 32'd5);
    preload(5'd2, 32'd7);
    run(ADD, 5'd1, 5'd2, 5'd3);
    chk("add_r3", bank[3], 32'd12);
    chk("add_write_edge", last_wb_cyc + 1 - last_acc_cyc, 3);

    preload(5'd1, 32'h0000_0003);
    preload(5'd2, 32'hFFFF_FFFE);
    run(SUB, 5'd1, 5'd2, 5'd4);
    chk("sub_r4", bank[4], 32'd5);
    run(SLT, 5'd1, 5'd2, 5'd5);
    chk("slt_r5", bank[5], 32'd0);
    run(SLT, 5'd2, 5'd1, 5'd6);
    chk("slt_r6", bank[6], 32'd1);
    run(SHL, 5'd2, 5'd1, 5'd7);
    chk("shl_r7", bank[7], 32'hFFFF_FFF0);

    preload(5'd1, 32'h0001_0001);
    preload(5'd2, 32'h0001_0001);
    issue(MUL, 5'd1, 5'd2, 5'd8);
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    in_valid = 1'b1; in_op = ADD; in_sr1 = 5'd1; in_sr2 = 5'd1; in_dr = 5'd9;
    repeat (3) @(posedge clk);
    #1;
    wait_done();
    chk("mul_r8", bank[8], 32'h0002_0001);
    chk("mul_write_edge", last_wb_cyc + 1 - last_acc_cyc, 34);

    preload(5'd1, 32'd5);
    issue(ADD, 5'd1, 5'd1, 5'd1);
    issue(ADD, 5'd1, 5'd1, 5'd6);
    wait_done();
    chk("b2b_r1", bank[1], 32'd10);
    chk("b2b_r6", bank[6], 32'd20);
    chk("b2b_spacing", last_acc_cyc - prev_acc_cyc, 4);

    preload(5'd9, 32'h0000_1234);
    preload(5'd10, 32'd3);
    preload(5'd11, 32'd5);
    issue(MUL, 5'd10, 5'd11, 5'd9);
    in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #3 reset_n = 1'b0;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_in_ready", in_ready, 0);
    chk("arst_write", write, 0);
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    @(posedge clk); #1;
    chk("arst_ready_after", in_ready, 1);
    repeat (40) @(posedge clk);
    #1;
    chk("arst_r9_kept", bank[9], 32'h0000_1234);
    run(ADD, 5'd10, 5'd11, 5'd12);
    chk("post_rst_add", bank[12], 32'd8);

    for (int r = 0; r < 32; r++) preload(5'(r), $urandom);
    for (int n = 0; n < 40; n++) begin
      logic [2:0] op;
      op = 3'($urandom_range(0, 7));
      if (op == MUL && $urandom_range(0, 2) != 0) op = ADD;
      issue(op, 5'($urandom), 5'($urandom), 5'($urandom));
    end
    wait_done();
    chk("rand_all_written", wr_count, acc_count);
    for (int r = 0; r < 32; r++) chk("final_bank", bank[r], model[r]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout actual=%0d required=0", cyc);
    $fatal(1, "timeout");
  end

endmodule
